// File: rtl/t1a_pwm_decoder.sv
// t1a_pwm_decoder
// Decodes a 16-step PWM input into a 4-bit duty value.
// - The input is synchronised, and each rising edge closes one measured period.
// - A rise in MEAS reports the period that just ended.
// - A rise in SYNC only arms the measurement, so a partial period is never reported.
// - If no rise arrives within TIMEOUT_CLKS cycles, the input is reported as stuck
//   at its current level.
module t1a_pwm_decoder #(
  parameter int PERIOD_CLKS  = 256,
  parameter int PERIOD_TOL   = 2,
  parameter int TIMEOUT_CLKS = 512
) (
  input  logic       clk_50M,
  input  logic       reset_n,
  input  logic       pwm_signal,
  output logic [3:0] duty_out,
  output logic       duty_valid,
  output logic       period_err,
  output logic       pwm_stuck
);

  // One duty step spans PERIOD_CLKS/16 cycles; adding half a step rounds to nearest.
  localparam int          DUTY_SHIFT = $clog2(PERIOD_CLKS / 16);
  localparam logic [10:0] DUTY_ROUND = 11'(PERIOD_CLKS / 32);
  localparam logic [10:0] PER_HI     = 11'(PERIOD_CLKS + PERIOD_TOL);
  localparam logic [10:0] PER_LO     = 11'(PERIOD_CLKS - PERIOD_TOL);
  localparam logic [9:0]  TIMEOUT_V  = 10'(TIMEOUT_CLKS);
  localparam logic [9:0]  CNT_MAX    = 10'd1023;

  typedef enum logic [0:0] {
    ST_SYNC = 1'b0,
    ST_MEAS = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic        s1_q, s1_d;
  logic        s2_q, s2_d;
  logic        s3_q, s3_d;
  logic [9:0]  period_cnt_q, period_cnt_d;
  logic [9:0]  high_cnt_q, high_cnt_d;
  logic [3:0]  duty_out_q, duty_out_d;
  logic        duty_valid_q, duty_valid_d;
  logic        period_err_q, period_err_d;
  logic        pwm_stuck_q, pwm_stuck_d;
  logic        rise;

  // Saturating increment keeps the counters pinned at full scale.
  function automatic logic [9:0] sat_inc(input logic [9:0] cnt);
    logic [9:0] res;
    if (cnt != CNT_MAX) begin
      res = cnt + 10'd1;
    end else begin
      res = cnt;
    end
    return res;
  endfunction

  // Rounded high time to duty step, clipped to the top step.
  function automatic logic [3:0] duty_calc(input logic [9:0] high);
    logic [10:0] sum;
    logic [10:0] step;
    logic [3:0]  res;
    sum  = {1'b0, high} + DUTY_ROUND;
    step = sum >> DUTY_SHIFT;
    if (step > 11'd15) begin
      res = 4'd15;
    end else begin
      res = step[3:0];
    end
    return res;
  endfunction

  // A period is bad when it falls outside the nominal value +/- the tolerance.
  function automatic logic period_bad(input logic [9:0] cnt);
    logic res;
    if (({1'b0, cnt} > PER_HI) || ({1'b0, cnt} < PER_LO)) begin
      res = 1'b1;
    end else begin
      res = 1'b0;
    end
    return res;
  endfunction

  assign rise = s2_q & ~s3_q;

  // Synchroniser chain: two metastability flops followed by an edge-detect delay flop.
  always_comb begin
    s1_d = pwm_signal;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // Measurement and reporting. A rise takes priority over a timeout in the same cycle.
  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    duty_out_d   = duty_out_q;
    duty_valid_d = 1'b0;
    period_err_d = period_err_q;
    pwm_stuck_d  = pwm_stuck_q;

    if (rise) begin
      period_cnt_d = 10'd1;
      high_cnt_d   = 10'd1;
      case (state_q)
        ST_SYNC: begin
          state_d = ST_MEAS;
        end
        ST_MEAS: begin
          state_d      = ST_MEAS;
          duty_out_d   = duty_calc(high_cnt_q);
          duty_valid_d = 1'b1;
          period_err_d = period_bad(period_cnt_q);
          pwm_stuck_d  = 1'b0;
        end
        default: begin
          state_d = ST_SYNC;
        end
      endcase
    end else if (period_cnt_q == TIMEOUT_V) begin
      // The input has not risen for a full timeout: report its level and re-arm.
      state_d      = ST_SYNC;
      period_cnt_d = 10'd0;
      high_cnt_d   = 10'd0;
      duty_out_d   = s2_q ? 4'd15 : 4'd0;
      duty_valid_d = 1'b1;
      period_err_d = 1'b0;
      pwm_stuck_d  = 1'b1;
    end else begin
      period_cnt_d = sat_inc(period_cnt_q);
      if (s2_q) begin
        high_cnt_d = sat_inc(high_cnt_q);
      end else begin
        high_cnt_d = high_cnt_q;
      end
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_SYNC;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      period_cnt_q <= 10'd0;
      high_cnt_q   <= 10'd0;
      duty_out_q   <= 4'd0;
      duty_valid_q <= 1'b0;
      period_err_q <= 1'b0;
      pwm_stuck_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      duty_out_q   <= duty_out_d;
      duty_valid_q <= duty_valid_d;
      period_err_q <= period_err_d;
      pwm_stuck_q  <= pwm_stuck_d;
    end
  end

  assign duty_out   = duty_out_q;
  assign duty_valid = duty_valid_q;
  assign period_err = period_err_q;
  assign pwm_stuck  = pwm_stuck_q;

endmodule
